// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state encoding, select bit positions and defaults for the CORDIC controller
package cordic_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, ITER, VALID} state_t;
    localparam int SEL_SIN    = 0;
    localparam int SEL_COS    = 1;
    localparam int SEL_TAN    = 2;
    localparam int SEL_ATAN   = 3;
    localparam int N_ITER_DEF = 6;
    function automatic logic is_onehot(input logic [3:0] s);
        return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
    endfunction
endpackage

// File: rtl/cordic_ctrl_if.sv
// cordic_ctrl_if: request/result handshake between register interface, controller and datapath
// master drives start/select/abort/out_ack; slave (the controller) drives busy, load, reg_en,
// iter_idx, sel_q, vectoring, out_valid and err.
interface cordic_ctrl_if #(
    parameter int IDX_W = 3
);
    logic             start;
    logic [3:0]       select;
    logic             abort;
    logic             out_ack;
    logic             busy;
    logic             load;
    logic             reg_en;
    logic [IDX_W-1:0] iter_idx;
    logic [3:0]       sel_q;
    logic             vectoring;
    logic             out_valid;
    logic             err;
    modport master (
        output start, select, abort, out_ack,
        input  busy, load, reg_en, iter_idx, sel_q, vectoring, out_valid, err
    );
    modport slave (
        input  start, select, abort, out_ack,
        output busy, load, reg_en, iter_idx, sel_q, vectoring, out_valid, err
    );
endinterface

// File: rtl/cordic_ctrl.sv
// cordic_ctrl: Moore sequencer driving CORDIC init-load, iteration enable/index and result-valid
// Ports: clk; rst_n (async, active-low); bus (slave modport of cordic_ctrl_if).
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = N_ITER_DEF,
    parameter int IDX_W  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    cordic_ctrl_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITER - 1);
    state_t           state, state_d;
    logic [IDX_W-1:0] cnt, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic             err_q, err_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sel_q <= 4'b0001;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sel_q <= sel_d;
            err_q <= err_d;
        end
    end
    // Counter clears everywhere except while stepping through ITER, so LOAD always starts it at 0.
    always_comb begin
        state_d = state;
        cnt_d   = '0;
        sel_d   = sel_q;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && is_onehot(bus.select)) begin
                    state_d = LOAD;
                    sel_d   = bus.select;
                end
                err_d = bus.start && !is_onehot(bus.select);
            end
            LOAD:  state_d = ITER;
            ITER: begin
                state_d = (cnt == LAST) ? VALID : ITER;
                cnt_d   = (cnt == LAST) ? '0 : cnt + IDX_W'(1);
            end
            VALID: state_d = bus.out_ack ? IDLE : VALID;
            default: state_d = IDLE;
        endcase
        if (bus.abort && state != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end
    assign bus.busy      = (state != IDLE);
    assign bus.load      = (state == LOAD);
    assign bus.reg_en    = (state == ITER);
    assign bus.iter_idx  = (state == ITER) ? cnt : '0;
    assign bus.sel_q     = sel_q;
    assign bus.vectoring = sel_q[SEL_ATAN];
    assign bus.out_valid = (state == VALID);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_cordic_ctrl.sv
// tb_cordic_ctrl: table-driven and hand-sequenced checks of cordic_ctrl with a result scoreboard
module tb_cordic_ctrl;
    localparam int N = 6;
    typedef struct {
        logic [3:0] sel;
        logic       rej;
        logic [3:0] selq;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] sb[$];
    vec_t       tbl[8];
    cordic_ctrl_if #(.IDX_W(3)) bus();
    cordic_ctrl #(.N_ITER(N), .IDX_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start(input logic [3:0] s);
        bus.start  = 1'b1;
        bus.select = s;
        tick();
        bus.start  = 1'b0;
    endtask
    task automatic wait_valid(input int n0);
        int n = n0;
        logic [3:0] e;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(N + 2));
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: out_valid with no pending result");
        end else begin
            e = sb.pop_front();
            chk("result_sel", 32'(bus.sel_q), 32'(e));
            chk("result_vect", 32'(bus.vectoring), 32'(e[3]));
        end
    endtask
    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_load"}, 32'(bus.load), 0);
        chk({nm, "_reg_en"}, 32'(bus.reg_en), 0);
        chk({nm, "_idx"}, 32'(bus.iter_idx), 0);
        chk({nm, "_valid"}, 32'(bus.out_valid), 0);
        chk({nm, "_err"}, 32'(bus.err), 0);
        chk({nm, "_vect"}, 32'(bus.vectoring), 0);
        chk({nm, "_sel_q"}, 32'(bus.sel_q), 32'h1);
    endtask
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        tbl[0] = '{4'b0001, 1'b0, 4'b0001};
        tbl[1] = '{4'b0010, 1'b0, 4'b0010};
        tbl[2] = '{4'b0000, 1'b1, 4'b0010};
        tbl[3] = '{4'b0110, 1'b1, 4'b0010};
        tbl[4] = '{4'b0100, 1'b0, 4'b0100};
        tbl[5] = '{4'b1111, 1'b1, 4'b0100};
        tbl[6] = '{4'b1000, 1'b0, 4'b1000};
        tbl[7] = '{4'b1001, 1'b1, 4'b1000};
        bus.start = 1'b0; bus.select = 4'b0000; bus.abort = 1'b0; bus.out_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;
        tick();
        // Nominal sin: ack withheld until cycle 12.
        sb.push_back(4'b0001);
        do_start(4'b0001);
        chk("t1_load", 32'(bus.load), 1);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_reg_en_c1", 32'(bus.reg_en), 0);
        for (int i = 0; i < N; i++) begin
            tick();
            chk("t1_reg_en", 32'(bus.reg_en), 1);
            chk("t1_idx", 32'(bus.iter_idx), 32'(i));
            chk("t1_load_off", 32'(bus.load), 0);
        end
        tick();
        wait_valid(N + 2);
        for (int c = 9; c <= 12; c++) begin
            if (c > 9) tick();
            chk("t1_valid_held", 32'(bus.out_valid), 1);
        end
        bus.out_ack = 1'b1;
        tick();
        chk("t1_busy_after_ack", 32'(bus.busy), 0);
        chk("t1_valid_after_ack", 32'(bus.out_valid), 0);
        chk("t1_idx_idle", 32'(bus.iter_idx), 0);
        // Table of accepted/rejected starts with out_ack tied high.
        for (int k = 0; k < 8; k++) begin
            if (!tbl[k].rej) sb.push_back(tbl[k].sel);
            do_start(tbl[k].sel);
            chk("tbl_err", 32'(bus.err), 32'(tbl[k].rej));
            chk("tbl_load", 32'(bus.load), 32'(!tbl[k].rej));
            chk("tbl_busy", 32'(bus.busy), 32'(!tbl[k].rej));
            chk("tbl_sel_q", 32'(bus.sel_q), 32'(tbl[k].selq));
            chk("tbl_vect", 32'(bus.vectoring), 32'(tbl[k].selq[3]));
            if (!tbl[k].rej) wait_valid(1);
            tick();
            chk("tbl_valid_one_cycle", 32'(bus.out_valid), 0);
            chk("tbl_err_one_cycle", 32'(bus.err), 0);
            chk("tbl_busy_end", 32'(bus.busy), 0);
        end
        // Abort mid-ITER, then a fresh operation.
        do_start(4'b0100);
        tick();
        tick();
        tick();
        chk("ab_idx", 32'(bus.iter_idx), 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab_busy", 32'(bus.busy), 0);
        chk("ab_reg_en", 32'(bus.reg_en), 0);
        chk("ab_valid", 32'(bus.out_valid), 0);
        chk("ab_err", 32'(bus.err), 0);
        chk("ab_sel_q", 32'(bus.sel_q), 32'h4);
        sb.push_back(4'b0010);
        do_start(4'b0010);
        chk("ab_restart_load", 32'(bus.load), 1);
        wait_valid(1);
        tick();
        // Abort while VALID is waiting for ack.
        bus.out_ack = 1'b0;
        sb.push_back(4'b1000);
        do_start(4'b1000);
        wait_valid(1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abv_valid", 32'(bus.out_valid), 0);
        chk("abv_busy", 32'(bus.busy), 0);
        chk("abv_err", 32'(bus.err), 0);
        // Starts while busy are ignored; start+ack in VALID only returns to IDLE.
        sb.push_back(4'b0001);
        do_start(4'b0001);
        tick();
        tick();
        bus.start = 1'b1; bus.select = 4'b0000;
        tick();
        bus.start = 1'b0;
        chk("ign_err", 32'(bus.err), 0);
        chk("ign_idx", 32'(bus.iter_idx), 2);
        wait_valid(4);
        bus.start = 1'b1; bus.select = 4'b0010; bus.out_ack = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign_busy", 32'(bus.busy), 0);
        chk("ign_valid", 32'(bus.out_valid), 0);
        chk("ign_sel_q", 32'(bus.sel_q), 32'h1);
        tick();
        chk("ign_no_queue_load", 32'(bus.load), 0);
        chk("ign_no_queue_busy", 32'(bus.busy), 0);
        // Asynchronous reset mid-ITER.
        do_start(4'b1000);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        chk("arst_hold_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        tick();
        sb.push_back(4'b0010);
        do_start(4'b0010);
        chk("arst_load", 32'(bus.load), 1);
        wait_valid(1);
        tick();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
